// File: rtl/shift_arbiter.sv
// shift_arbiter: arbitrates two requesters onto one left-shift datapath.
// Right shifts bit-reverse the operand and the result around the left shifter.
// The result is held in a single output register. It is owned by the port that
// was granted and is released when that port's resp_ready is high.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH),
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SW-1:0]    req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SW-1:0]    req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_y,
  output logic             busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state_p1;
  state_t           state_nxt;
  logic             owner_p1;
  logic             rr_ptr;
  logic [WIDTH-1:0] y_p1;

  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] sel_a;
  logic [SW-1:0]    sel_shamt;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] shift_y;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // One left shifter serves every op; right shifts go through bit reversal.
  // The SRA fill mask sets the top shamt bits when the operand is negative.
  // The reserved op falls through to SLL.
  function automatic logic [WIDTH-1:0] shift_calc(input logic [WIDTH-1:0] a,
                                                  input logic [SW-1:0]    sh,
                                                  input logic [1:0]       op);
    logic [WIDTH-1:0] srl_y;
    logic [WIDTH-1:0] fill;
    srl_y = bit_rev(bit_rev(a) << sh);
    fill  = ~({WIDTH{1'b1}} >> sh);
    case (op)
      OP_SRL:  return srl_y;
      OP_SRA:  return a[WIDTH-1] ? (srl_y | fill) : srl_y;
      default: return a << sh;
    endcase
  endfunction

  // Grant: the slot is free when empty or when the owner drains this cycle.
  // No grant is issued while rst is high.
  always_comb begin
    slot_free = (state_p1 == EMPTY) || (owner_p1 ? resp1_ready : resp0_ready);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slot_free && !rst) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && rr_ptr) gnt1 = 1'b1;
        else                 gnt0 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Operand mux feeding the shared shifter from the granted port
  always_comb begin
    sel_a     = gnt1 ? req1_a     : req0_a;
    sel_shamt = gnt1 ? req1_shamt : req0_shamt;
    sel_op    = gnt1 ? req1_op    : req0_op;
    shift_y   = shift_calc(sel_a, sel_shamt, sel_op);
  end

  // Next state: a grant fills the slot, and a drain without a grant empties it
  always_comb begin
    state_nxt = state_p1;
    if (gnt0 || gnt1) begin
      state_nxt = FULL;
    end else if (slot_free) begin
      state_nxt = EMPTY;
    end
  end

  // ---- stage p1: control registers (occupancy, owner, round-robin pointer)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= EMPTY;
      owner_p1 <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (gnt0 || gnt1) begin
        owner_p1 <= gnt1;
        rr_ptr   <= ~gnt1;
      end
    end
  end

  // Result register: loads only on a grant and is cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1 <= '0;
    end else if (gnt0 || gnt1) begin
      y_p1 <= shift_y;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp0_valid = (state_p1 == FULL) && !owner_p1;
  assign resp1_valid = (state_p1 == FULL) &&  owner_p1;
  assign busy        = (state_p1 == FULL);
  assign resp_y      = y_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter. Directed requests push their hand-computed results
// into a scoreboard queue, and a monitor pops and compares each consumed
// response. A second instance with RR_EN=0 covers fixed priority.
module tb_shift_arbiter;

  localparam int W = 32;
  localparam int S = 5;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, RSV = 2'b11;

  typedef struct packed {
    logic         port;
    logic [W-1:0] y;
  } exp_t;

  logic clk, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req1_a;
  logic [S-1:0] req0_shamt, req1_shamt;
  logic [1:0] req0_op, req1_op;
  logic resp0_valid, resp0_ready, resp1_valid, resp1_ready, busy;
  logic [W-1:0] resp_y;

  logic f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [W-1:0] f_req0_a, f_req1_a;
  logic [S-1:0] f_req0_shamt, f_req1_shamt;
  logic [1:0] f_req0_op, f_req1_op;
  logic f_resp0_valid, f_resp0_ready, f_resp1_valid, f_resp1_ready, f_busy;
  logic [W-1:0] f_resp_y;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  shift_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_y(resp_y), .busy(busy)
  );

  shift_arbiter #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a),
    .req0_shamt(f_req0_shamt), .req0_op(f_req0_op),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a),
    .req1_shamt(f_req1_shamt), .req1_op(f_req1_op),
    .resp0_valid(f_resp0_valid), .resp0_ready(f_resp0_ready),
    .resp1_valid(f_resp1_valid), .resp1_ready(f_resp1_ready),
    .resp_y(f_resp_y), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [W-1:0] y);
    exp_t e;
    e.port = port;
    e.y    = y;
    sb.push_back(e);
  endtask

  // Present one request, wait (bounded) for ready, record the expected result
  task automatic issue(input logic port, input logic [W-1:0] a, input logic [S-1:0] sh,
                       input logic [1:0] op, input logic [W-1:0] y);
    int n;
    logic rdy;
    if (!port) begin
      req0_a = a; req0_shamt = sh; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_shamt = sh; req1_op = op; req1_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    rdy = port ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = port ? req1_ready : req0_ready;
      n++;
    end
    chk1("issue_accepted", rdy, 1'b1);
    if (rdy) push(port, y);
    @(posedge clk); #1;
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
  endtask

  // Monitor: every consumed response must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got port %0b y=0x%08h expected no response",
                   resp1_valid, resp_y);
        end else begin
          e = sb.pop_front();
          chk1("resp_port", resp1_valid, e.port);
          chk("resp_y", resp_y, e.y);
          chk1("busy_with_resp", busy, 1'b1);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'h1; req0_shamt = 5'd31; req0_op = SLL;
    req1_a = '0; req1_shamt = '0; req1_op = SLL;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    f_req0_a = 32'h5; f_req0_shamt = 5'd3; f_req0_op = SLL;
    f_req1_a = 32'h9; f_req1_shamt = 5'd1; f_req1_op = SLL;
    f_resp0_ready = 1'b1; f_resp1_ready = 1'b1;

    // Reset: a request presented under reset is not accepted
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_resp0_valid", resp0_valid, 1'b0);
    chk1("rst_resp1_valid", resp1_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_resp_y", resp_y, 32'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Fixed priority instance: port 0 always wins, port 1 starved
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("fp_req0_ready", f_req0_ready, 1'b1);
      chk1("fp_req1_ready", f_req1_ready, 1'b0);
      if (i > 0) begin
        chk1("fp_resp0_valid", f_resp0_valid, 1'b1);
        chk("fp_resp_y", f_resp_y, 32'h0000_0028);
      end
      @(posedge clk); #1;
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    chk1("fp_resp1_never", f_resp1_valid, 1'b0);

    // Single requests across ops and boundaries
    issue(1'b0, 32'h0000_0001, 5'd31, SLL, 32'h8000_0000);
    chk1("lat_resp0_valid", resp0_valid, 1'b1);
    chk1("lat_busy", busy, 1'b1);
    chk("lat_resp_y", resp_y, 32'h8000_0000);
    issue(1'b0, 32'h0000_00FF, 5'd8,  RSV, 32'h0000_FF00);
    issue(1'b0, 32'h1234_5678, 5'd0,  SRA, 32'h1234_5678);
    issue(1'b1, 32'h8000_00F0, 5'd4,  SRA, 32'hF800_000F);
    issue(1'b1, 32'h8000_00F0, 5'd4,  SRL, 32'h0800_000F);
    issue(1'b1, 32'h8765_4321, 5'd0,  SRL, 32'h8765_4321);

    // Round robin: both valid, responses consumed; grants 0,1,0,1
    req0_a = 32'h3; req0_shamt = 5'd1; req0_op = SLL;
    req1_a = 32'hC; req1_shamt = 5'd2; req1_op = SRL;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("rr_req0_ready", req0_ready, (i % 2) == 0);
      chk1("rr_req1_ready", req1_ready, (i % 2) == 1);
      if (req0_ready) push(1'b0, 32'h6);
      if (req1_ready) push(1'b1, 32'h3);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: the owner stalls 3 cycles, then drain and regrant together
    resp0_ready = 1'b0;
    issue(1'b0, 32'h0000_00A5, 5'd4, SLL, 32'h0000_0A50);
    req1_a = 32'h1; req1_shamt = 5'd1; req1_op = SLL; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("bp_resp0_valid", resp0_valid, 1'b1);
      chk("bp_resp_y", resp_y, 32'h0000_0A50);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      chk1("bp_req1_ready", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_drain_regrant", req1_ready, 1'b1);
    if (req1_ready) push(1'b1, 32'h2);
    @(posedge clk); #1;
    req1_valid = 1'b0;

    // Reset while FULL with a pending request: result dropped, rr_ptr back to 0
    resp0_ready = 1'b0;
    req0_a = 32'h1; req0_shamt = 5'd4; req0_op = SLL; req0_valid = 1'b1;
    @(negedge clk);
    chk1("rf_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk1("rf_rst_req0_ready", req0_ready, 1'b0);
    chk1("rf_rst_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk1("rf_resp0_valid", resp0_valid, 1'b0);
    chk1("rf_resp1_valid", resp1_valid, 1'b0);
    chk1("rf_busy", busy, 1'b0);
    chk("rf_resp_y", resp_y, 32'h0);
    resp0_ready = 1'b1;
    req0_a = 32'h2;  req0_shamt = 5'd1; req0_op = SLL;
    req1_a = 32'h80; req1_shamt = 5'd7; req1_op = SRL;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk1("rf_rrptr_req0", req0_ready, 1'b1);
    chk1("rf_rrptr_req1", req1_ready, 1'b0);
    if (req0_ready) push(1'b0, 32'h4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Let the scoreboard drain (bounded)
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
